// File: rtl/img_udp_packetizer.sv
// Camera line packetizer: gates frames, packs pixel pairs into a line FIFO,
// and hands one UDP packet per complete line to the TX engine.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   transfer_flag      enable sampled at each vsync rising edge
//   cam_vsync, cam_de  frame sync / pixel valid
//   cam_data[15:0]     pixel
//   udp_tx_req         TX engine word request (data one cycle later)
//   udp_tx_done        TX engine packet complete pulse
//   udp_tx_start_en    packet start pulse
//   udp_tx_byte_num    packet length in bytes
//   udp_tx_data        payload word
//   frame_busy         current frame is being captured
//   ovf_err            sticky: a line was dropped
module img_udp_packetizer #(
    parameter int          H_PIXEL    = 640,
    parameter logic [31:0] FRAME_HEAD = 32'hF05A_A50F,
    parameter int          FIFO_AW    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        transfer_flag,
    input  logic        cam_vsync,
    input  logic        cam_de,
    input  logic [15:0] cam_data,
    input  logic        udp_tx_req,
    input  logic        udp_tx_done,
    output logic        udp_tx_start_en,
    output logic [15:0] udp_tx_byte_num,
    output logic [31:0] udp_tx_data,
    output logic        frame_busy,
    output logic        ovf_err
);

    localparam int               DEPTH      = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] PTR_FULL   = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0] PTR_ONE    = (FIFO_AW + 1)'(1);
    localparam logic [15:0]      LINE_BYTES = 16'(H_PIXEL * 2);
    localparam logic [15:0]      LINE_WORDS = 16'(H_PIXEL / 2);
    localparam logic [15:0]      LINE_PIX   = 16'(H_PIXEL);

    typedef enum logic [1:0] {IDLE, START, SEND, WAIT} state_t;

    logic [31:0]      mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr, wr_cmt, rd_ptr;
    logic             vsync_d, de_d;
    logic             line_on, line_bad, line_hdr;
    logic [15:0]      pix_cnt, pix_hi;
    logic [3:0]       dq_hdr;
    logic [2:0]       dq_wp, dq_rp;
    state_t           state;
    logic [15:0]      words_left;

    logic             vs_rise, de_rise, de_fall, take;
    logic             full, full_cmt, dq_full, dq_empty, len_ok;
    logic             we;
    logic [FIFO_AW-1:0] waddr;
    logic [31:0]      wdata;

    assign vs_rise  = cam_vsync & ~vsync_d;
    assign de_rise  = cam_de & ~de_d;
    // Only lines that were accepted at their first pixel can end.
    assign de_fall  = ~cam_de & de_d & line_on;
    assign take     = ~vs_rise & cam_de & (line_on | (de_rise & frame_busy));
    // Full is judged against the speculative pointer so an
    // uncommitted line can never overwrite unread words.
    assign full     = (wr_ptr ^ rd_ptr) == PTR_FULL;
    assign full_cmt = (wr_cmt ^ rd_ptr) == PTR_FULL;
    assign dq_full  = (dq_wp ^ dq_rp) == 3'b100;
    assign dq_empty = dq_wp == dq_rp;
    assign len_ok   = pix_cnt == LINE_PIX;

    always_comb begin
        we    = 1'b0;
        waddr = wr_ptr[FIFO_AW-1:0];
        wdata = {pix_hi, cam_data};
        if (vs_rise) begin
            // Header lands at the committed pointer, which also
            // discards any partial line from the previous frame.
            waddr = wr_cmt[FIFO_AW-1:0];
            wdata = FRAME_HEAD;
            we    = transfer_flag & ~full_cmt;
        end else if (take && pix_cnt[0] && !line_bad && !full) begin
            we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d    <= 1'b0;
            de_d       <= 1'b0;
            frame_busy <= 1'b0;
            ovf_err    <= 1'b0;
            line_on    <= 1'b0;
            line_bad   <= 1'b0;
            line_hdr   <= 1'b0;
            pix_cnt    <= '0;
            pix_hi     <= '0;
            wr_ptr     <= '0;
            wr_cmt     <= '0;
            dq_hdr     <= '0;
            dq_wp      <= '0;
        end else begin
            vsync_d <= cam_vsync;
            de_d    <= cam_de;
            if (vs_rise) begin
                frame_busy <= transfer_flag;
                line_hdr   <= transfer_flag;
                line_bad   <= transfer_flag & full_cmt;
                line_on    <= 1'b0;
                pix_cnt    <= '0;
                wr_ptr     <= we ? wr_cmt + PTR_ONE : wr_cmt;
            end else if (de_fall) begin
                line_on  <= 1'b0;
                line_bad <= 1'b0;
                line_hdr <= 1'b0;
                pix_cnt  <= '0;
                if (len_ok && !line_bad && !dq_full) begin
                    wr_cmt             <= wr_ptr;
                    dq_hdr[dq_wp[1:0]] <= line_hdr;
                    dq_wp              <= dq_wp + 3'd1;
                end else begin
                    wr_ptr  <= wr_cmt;
                    ovf_err <= 1'b1;
                    // A full-length line lost to lack of space means the
                    // reader is behind: drop the rest of the frame.
                    if (len_ok) frame_busy <= 1'b0;
                end
            end else if (take) begin
                line_on <= 1'b1;
                if (pix_cnt != 16'hFFFF) pix_cnt <= pix_cnt + 16'd1;
                if (!pix_cnt[0]) pix_hi <= cam_data;
                else if (we) wr_ptr <= wr_ptr + PTR_ONE;
                else line_bad <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            udp_tx_start_en <= 1'b0;
            udp_tx_byte_num <= '0;
            udp_tx_data     <= '0;
            rd_ptr          <= '0;
            dq_rp           <= '0;
            words_left      <= '0;
        end else begin
            udp_tx_start_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!dq_empty) begin
                        state           <= START;
                        udp_tx_start_en <= 1'b1;
                        udp_tx_byte_num <= LINE_BYTES +
                            (dq_hdr[dq_rp[1:0]] ? 16'd4 : 16'd0);
                        words_left      <= LINE_WORDS +
                            {15'd0, dq_hdr[dq_rp[1:0]]};
                    end
                end
                START: state <= SEND;
                SEND: begin
                    if (udp_tx_req) begin
                        udp_tx_data <= mem[rd_ptr[FIFO_AW-1:0]];
                        rd_ptr      <= rd_ptr + PTR_ONE;
                        words_left  <= words_left - 16'd1;
                        if (words_left == 16'd1) state <= WAIT;
                    end
                end
                WAIT: begin
                    if (udp_tx_done) begin
                        dq_rp <= dq_rp + 3'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_img_udp_packetizer.sv
// Randomized bench for img_udp_packetizer with a packet-level model:
// expected packets/words are derived from whole lines and frame rules.
module tb_img_udp_packetizer;

    localparam int          H     = 8;
    localparam int          AW    = 3;
    localparam int          DEPTH = 8;
    localparam logic [31:0] HEAD  = 32'hF05A_A50F;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        transfer_flag = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_de = 1'b0;
    logic [15:0] cam_data = '0;
    logic        udp_tx_req = 1'b0;
    logic        udp_tx_done = 1'b0;
    logic        udp_tx_start_en;
    logic [15:0] udp_tx_byte_num;
    logic [31:0] udp_tx_data;
    logic        frame_busy;
    logic        ovf_err;

    always #5 clk = ~clk;

    img_udp_packetizer #(
        .H_PIXEL(H), .FRAME_HEAD(HEAD), .FIFO_AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .transfer_flag(transfer_flag),
        .cam_vsync(cam_vsync), .cam_de(cam_de), .cam_data(cam_data),
        .udp_tx_req(udp_tx_req), .udp_tx_done(udp_tx_done),
        .udp_tx_start_en(udp_tx_start_en),
        .udp_tx_byte_num(udp_tx_byte_num), .udp_tx_data(udp_tx_data),
        .frame_busy(frame_busy), .ovf_err(ovf_err)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit hold = 1'b0;
    int done_cnt = 0;
    logic [15:0] rx_bytes[$];
    logic [31:0] rx_words[$];
    logic [15:0] exp_bytes[$];
    logic [31:0] exp_words[$];
    bit m_busy = 1'b0;
    bit m_hdr = 1'b0;

    // TX engine stand-in: records every packet it is offered.
    initial begin
        int n;
        forever begin
            @(negedge clk);
            if (rst_n && udp_tx_start_en) begin
                rx_bytes.push_back(udp_tx_byte_num);
                n = int'(udp_tx_byte_num) / 4;
                @(negedge clk);
                for (int i = 0; i < n; i++) begin
                    while (hold && rst_n) @(negedge clk);
                    if (!rst_n) break;
                    udp_tx_req = 1'b1;
                    @(negedge clk);
                    udp_tx_req = 1'b0;
                    rx_words.push_back(udp_tx_data);
                end
                if (rst_n) begin
                    @(negedge clk);
                    udp_tx_done = 1'b1;
                    @(negedge clk);
                    udp_tx_done = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic m_vsync();
        m_busy = transfer_flag;
        m_hdr  = transfer_flag;
    endtask

    task automatic m_line(input logic [15:0] pix[$]);
        int words, occ, pend;
        if (!m_busy) return;
        if (pix.size() != H) begin
            m_hdr = 1'b0;
            return;
        end
        words = H / 2 + (m_hdr ? 1 : 0);
        occ   = exp_words.size() - rx_words.size();
        pend  = exp_bytes.size() - done_cnt;
        if (occ + words > DEPTH || pend >= 4) begin
            m_busy = 1'b0;
            m_hdr  = 1'b0;
            return;
        end
        exp_bytes.push_back(16'(2 * H + (m_hdr ? 4 : 0)));
        if (m_hdr) exp_words.push_back(HEAD);
        for (int i = 0; i < H; i += 2)
            exp_words.push_back({pix[i], pix[i+1]});
        m_hdr = 1'b0;
    endtask

    task automatic cyc(input bit vs, input bit de, input logic [15:0] d);
        cam_vsync = vs;
        cam_de    = de;
        cam_data  = d;
        @(negedge clk);
    endtask

    task automatic vsync_pulse();
        m_vsync();
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 0);
    endtask

    task automatic send_line(input int n, input bit seq);
        logic [15:0] pix[$];
        for (int i = 0; i < n; i++) begin
            pix.push_back(seq ? 16'(i + 1) : 16'($urandom));
            cyc(0, 1, pix[i]);
        end
        cyc(0, 0, 0);
        m_line(pix);
        repeat (23) cyc(0, 0, 0);
    endtask

    task automatic clear_q();
        rx_bytes.delete();
        rx_words.delete();
        exp_bytes.delete();
        exp_words.delete();
        done_cnt = 0;
    endtask

    task automatic wait_drain(output bit ok);
        int t;
        t = 0;
        while ((rx_words.size() < exp_words.size() ||
                done_cnt < exp_bytes.size()) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (10) @(negedge clk);
        ok = (t < 2000);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (udp_tx_start_en !== 1'b0) begin n_err++;
            $display("FAIL reset_start: got %b want 0", udp_tx_start_en); end
        n_cmp++; if (udp_tx_byte_num !== 16'd0) begin n_err++;
            $display("FAIL reset_bytes: got %0d want 0", udp_tx_byte_num); end
        n_cmp++; if (udp_tx_data !== 32'd0) begin n_err++;
            $display("FAIL reset_data: got %h want 0", udp_tx_data); end
        n_cmp++; if (frame_busy !== 1'b0) begin n_err++;
            $display("FAIL reset_busy: got %b want 0", frame_busy); end
        n_cmp++; if (ovf_err !== 1'b0) begin n_err++;
            $display("FAIL reset_ovf: got %b want 0", ovf_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        clear_q();
        transfer_flag = 1'b1;
        vsync_pulse();
        n_cmp++; if (frame_busy !== 1'b1) begin n_err++;
            $display("FAIL basic_busy: got %b want 1", frame_busy); end
        repeat (4) send_line(H, 1'b1);
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_err++;
            $display("FAIL basic_drain: timeout rx=%0d exp=%0d",
                     rx_words.size(), exp_words.size()); end
        n_cmp++; if (rx_bytes.size() != 4) begin n_err++;
            $display("FAIL basic_npkt: got %0d want 4", rx_bytes.size()); end
        n_cmp++; if (rx_bytes.size() < 2 || rx_bytes[0] !== 16'd20 ||
                     rx_bytes[1] !== 16'd16) begin n_err++;
            $display("FAIL basic_len: got %0d,%0d want 20,16",
                     rx_bytes[0], rx_bytes[1]); end
        n_cmp++; if (rx_words.size() < 3 || rx_words[0] !== HEAD ||
                     rx_words[1] !== 32'h0001_0002 ||
                     rx_words[2] !== 32'h0003_0004) begin n_err++;
            $display("FAIL basic_words: got %h %h %h want f05aa50f 00010002 00030004",
                     rx_words[0], rx_words[1], rx_words[2]); end
        n_cmp++; if (rx_words.size() != exp_words.size()) begin n_err++;
            $display("FAIL basic_nword: got %0d want %0d",
                     rx_words.size(), exp_words.size()); end
        foreach (exp_words[i]) begin
            n_cmp++;
            if (i >= rx_words.size() || rx_words[i] !== exp_words[i]) begin
                n_err++;
                $display("FAIL basic_word%0d: got %h want %h",
                         i, rx_words[i], exp_words[i]);
            end
        end
        n_cmp++; if (ovf_err !== 1'b0) begin n_err++;
            $display("FAIL basic_ovf: got %b want 0", ovf_err); end
    endtask

    task automatic test_flag_toggle();
        bit ok;
        clear_q();
        transfer_flag = 1'b1;
        vsync_pulse();
        send_line(H, 1'b0);
        transfer_flag = 1'b0;
        repeat (3) send_line(H, 1'b0);
        n_cmp++; if (frame_busy !== 1'b1) begin n_err++;
            $display("FAIL flag_busy_mid: got %b want 1", frame_busy); end
        vsync_pulse();
        n_cmp++; if (frame_busy !== 1'b0) begin n_err++;
            $display("FAIL flag_busy_off: got %b want 0", frame_busy); end
        repeat (2) send_line(H, 1'b0);
        transfer_flag = 1'b1;
        vsync_pulse();
        send_line(H, 1'b0);
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_err++;
            $display("FAIL flag_drain: timeout"); end
        n_cmp++; if (rx_bytes.size() != exp_bytes.size()) begin n_err++;
            $display("FAIL flag_npkt: got %0d want %0d",
                     rx_bytes.size(), exp_bytes.size()); end
        foreach (exp_bytes[i]) begin
            n_cmp++;
            if (i >= rx_bytes.size() || rx_bytes[i] !== exp_bytes[i]) begin
                n_err++;
                $display("FAIL flag_len%0d: got %0d want %0d",
                         i, rx_bytes[i], exp_bytes[i]);
            end
        end
        n_cmp++; if (rx_words.size() != exp_words.size()) begin n_err++;
            $display("FAIL flag_nword: got %0d want %0d",
                     rx_words.size(), exp_words.size()); end
        foreach (exp_words[i]) begin
            n_cmp++;
            if (i >= rx_words.size() || rx_words[i] !== exp_words[i]) begin
                n_err++;
                $display("FAIL flag_word%0d: got %h want %h",
                         i, rx_words[i], exp_words[i]);
            end
        end
    endtask

    task automatic test_vsync_midline();
        bit ok;
        clear_q();
        transfer_flag = 1'b1;
        vsync_pulse();
        send_line(H, 1'b0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'($urandom));
        m_vsync();
        cyc(1, 1, 16'($urandom));
        cyc(1, 1, 16'($urandom));
        cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 0);
        send_line(H, 1'b0);
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_err++;
            $display("FAIL midv_drain: timeout"); end
        n_cmp++; if (ovf_err !== 1'b0) begin n_err++;
            $display("FAIL midv_ovf: got %b want 0", ovf_err); end
        n_cmp++; if (rx_bytes.size() != exp_bytes.size()) begin n_err++;
            $display("FAIL midv_npkt: got %0d want %0d",
                     rx_bytes.size(), exp_bytes.size()); end
        foreach (exp_bytes[i]) begin
            n_cmp++;
            if (i >= rx_bytes.size() || rx_bytes[i] !== exp_bytes[i]) begin
                n_err++;
                $display("FAIL midv_len%0d: got %0d want %0d",
                         i, rx_bytes[i], exp_bytes[i]);
            end
        end
        n_cmp++; if (rx_words.size() != exp_words.size()) begin n_err++;
            $display("FAIL midv_nword: got %0d want %0d",
                     rx_words.size(), exp_words.size()); end
        foreach (exp_words[i]) begin
            n_cmp++;
            if (i >= rx_words.size() || rx_words[i] !== exp_words[i]) begin
                n_err++;
                $display("FAIL midv_word%0d: got %h want %h",
                         i, rx_words[i], exp_words[i]);
            end
        end
    endtask

    task automatic test_bad_length();
        bit ok;
        clear_q();
        transfer_flag = 1'b1;
        vsync_pulse();
        send_line(H, 1'b0);
        send_line(H - 2, 1'b0);
        n_cmp++; if (ovf_err !== 1'b1) begin n_err++;
            $display("FAIL badlen_ovf: got %b want 1", ovf_err); end
        repeat (2) send_line(H, 1'b0);
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_err++;
            $display("FAIL badlen_drain: timeout"); end
        n_cmp++; if (frame_busy !== 1'b1) begin n_err++;
            $display("FAIL badlen_busy: got %b want 1", frame_busy); end
        n_cmp++; if (rx_bytes.size() != exp_bytes.size()) begin n_err++;
            $display("FAIL badlen_npkt: got %0d want %0d",
                     rx_bytes.size(), exp_bytes.size()); end
        n_cmp++; if (rx_words.size() != exp_words.size()) begin n_err++;
            $display("FAIL badlen_nword: got %0d want %0d",
                     rx_words.size(), exp_words.size()); end
        foreach (exp_words[i]) begin
            n_cmp++;
            if (i >= rx_words.size() || rx_words[i] !== exp_words[i]) begin
                n_err++;
                $display("FAIL badlen_word%0d: got %h want %h",
                         i, rx_words[i], exp_words[i]);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_q();
        hold = 1'b1;
        transfer_flag = 1'b1;
        vsync_pulse();
        repeat (4) send_line(H, 1'b0);
        n_cmp++; if (ovf_err !== 1'b1) begin n_err++;
            $display("FAIL ovf_flag: got %b want 1", ovf_err); end
        n_cmp++; if (frame_busy !== 1'b0) begin n_err++;
            $display("FAIL ovf_busy: got %b want 0", frame_busy); end
        n_cmp++; if (rx_words.size() != 0) begin n_err++;
            $display("FAIL ovf_noread: got %0d words want 0", rx_words.size()); end
        hold = 1'b0;
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_err++;
            $display("FAIL ovf_drain: timeout"); end
        repeat (100) @(negedge clk);
        n_cmp++; if (rx_bytes.size() != exp_bytes.size()) begin n_err++;
            $display("FAIL ovf_npkt: got %0d want %0d",
                     rx_bytes.size(), exp_bytes.size()); end
        n_cmp++; if (rx_words.size() != exp_words.size()) begin n_err++;
            $display("FAIL ovf_nword: got %0d want %0d",
                     rx_words.size(), exp_words.size()); end
        foreach (exp_words[i]) begin
            n_cmp++;
            if (i >= rx_words.size() || rx_words[i] !== exp_words[i]) begin
                n_err++;
                $display("FAIL ovf_word%0d: got %h want %h",
                         i, rx_words[i], exp_words[i]);
            end
        end
        clear_q();
        vsync_pulse();
        send_line(H, 1'b0);
        wait_drain(ok);
        n_cmp++; if (rx_bytes.size() != 1 || rx_bytes[0] !== 16'd20) begin
            n_err++;
            $display("FAIL ovf_resume: got %0d pkts len %0d want 1 len 20",
                     rx_bytes.size(), rx_bytes[0]); end
        foreach (exp_words[i]) begin
            n_cmp++;
            if (i >= rx_words.size() || rx_words[i] !== exp_words[i]) begin
                n_err++;
                $display("FAIL ovf_rword%0d: got %h want %h",
                         i, rx_words[i], exp_words[i]);
            end
        end
    endtask

    task automatic test_reset_in_send();
        bit ok;
        clear_q();
        hold = 1'b1;
        transfer_flag = 1'b1;
        vsync_pulse();
        send_line(H, 1'b0);
        n_cmp++; if (rx_bytes.size() != 1) begin n_err++;
            $display("FAIL rst_started: got %0d pkts want 1", rx_bytes.size()); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (udp_tx_byte_num !== 16'd0 || udp_tx_start_en !== 1'b0) begin
            n_err++;
            $display("FAIL rst_tx: got len %0d start %b want 0 0",
                     udp_tx_byte_num, udp_tx_start_en); end
        n_cmp++; if (udp_tx_data !== 32'd0) begin n_err++;
            $display("FAIL rst_data: got %h want 0", udp_tx_data); end
        n_cmp++; if (frame_busy !== 1'b0 || ovf_err !== 1'b0) begin n_err++;
            $display("FAIL rst_flags: got busy %b ovf %b want 0 0",
                     frame_busy, ovf_err); end
        repeat (3) @(negedge clk);
        hold = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_q();
        m_busy = 1'b0;
        m_hdr  = 1'b0;
        vsync_pulse();
        repeat (2) send_line(H, 1'b0);
        wait_drain(ok);
        n_cmp++; if (!ok) begin n_err++;
            $display("FAIL rst_drain: timeout"); end
        n_cmp++; if (rx_bytes.size() != 2 || rx_bytes[0] !== 16'd20) begin
            n_err++;
            $display("FAIL rst_resume: got %0d pkts len %0d want 2 len 20",
                     rx_bytes.size(), rx_bytes[0]); end
        foreach (exp_words[i]) begin
            n_cmp++;
            if (i >= rx_words.size() || rx_words[i] !== exp_words[i]) begin
                n_err++;
                $display("FAIL rst_word%0d: got %h want %h",
                         i, rx_words[i], exp_words[i]);
            end
        end
        n_cmp++; if (ovf_err !== 1'b0) begin n_err++;
            $display("FAIL rst_ovf: got %b want 0", ovf_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flag_toggle();
        test_vsync_midline();
        test_bad_length();
        test_overflow();
        test_reset_in_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
